// File: rtl/exp4_unidade_controle_pkg.sv
// Shared definitions for the memory-game control unit: state codes,
// the state enum, and the Moore output bundle with its decoder.
package exp4_unidade_controle_pkg;

    // The debug port shows these raw codes. Benches and top levels decode db_estado with them.
    localparam logic [3:0] EST_INICIAL     = 4'h0;
    localparam logic [3:0] EST_PREPARA     = 4'h1;
    localparam logic [3:0] EST_ESPERA      = 4'h2;
    localparam logic [3:0] EST_REGISTRA    = 4'h4;
    localparam logic [3:0] EST_COMPARA     = 4'h5;
    localparam logic [3:0] EST_PROXIMO     = 4'h6;
    localparam logic [3:0] EST_FIM_ACERTO  = 4'hA;
    localparam logic [3:0] EST_FIM_TIMEOUT = 4'hD;
    localparam logic [3:0] EST_FIM_ERRO    = 4'hE;

    typedef enum logic [3:0] {
        INICIAL     = EST_INICIAL,
        PREPARA     = EST_PREPARA,
        ESPERA      = EST_ESPERA,
        REGISTRA    = EST_REGISTRA,
        COMPARA     = EST_COMPARA,
        PROXIMO     = EST_PROXIMO,
        FIM_ACERTO  = EST_FIM_ACERTO,
        FIM_TIMEOUT = EST_FIM_TIMEOUT,
        FIM_ERRO    = EST_FIM_ERRO
    } estado_t;

    typedef struct packed {
        logic zera_c;
        logic conta_c;
        logic zera_r;
        logic registra_r;
        logic pronto;
        logic acertou;
        logic errou;
        logic timeout;
    } saidas_t;

    function automatic saidas_t decode_saidas(input estado_t estado);
        saidas_t s;
        s = '0;
        case (estado)
            PREPARA: begin
                s.zera_c = 1'b1;
                s.zera_r = 1'b1;
            end
            REGISTRA:   s.registra_r = 1'b1;
            PROXIMO:    s.conta_c    = 1'b1;
            FIM_ACERTO: begin
                s.pronto  = 1'b1;
                s.acertou = 1'b1;
            end
            FIM_ERRO: begin
                s.pronto = 1'b1;
                s.errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                s.pronto  = 1'b1;
                s.errou   = 1'b1;
                s.timeout = 1'b1;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/exp4_unidade_controle_edge_detector.sv
// Two-flop synchronizer followed by a rising-edge detector. A held input
// gives one pulse; the input must fall before another pulse can occur.
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal_i,
    output logic pulso_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sinal_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulso_o = sync2_q & ~prev_q;

endmodule

// File: rtl/exp4_unidade_controle.sv
// Moore control FSM for the memory game. For each ROM address it waits for a move,
// latches it, and compares it. It then advances or ends the round (hit, miss, or timeout).
module exp4_unidade_controle
    import exp4_unidade_controle_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned TW             = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    input  logic       chavesIgualMemoria,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    localparam bit          TMO_EN  = (TIMEOUT_CYCLES != 0);
    localparam int unsigned LIM_INT = TMO_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TW-1:0] TMO_LIM = TW'(LIM_INT);

    estado_t       estado_q, estado_d;
    saidas_t       saidas_q;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          jogada;
    logic          jogada_p;
    logic          tmo_hit;

    assign jogada = |chaves;

    edge_detector u_edge (
        .clock   (clock),
        .reset   (reset),
        .sinal_i (jogada),
        .pulso_o (jogada_p)
    );

    // The count is zero on the first ESPERA cycle, so the hit comes after TIMEOUT_CYCLES cycles.
    assign tmo_hit = TMO_EN && (tmo_cnt_q == TMO_LIM);

    always_comb begin
        tmo_cnt_d = '0;
        if (estado_q == ESPERA) begin
            if (TMO_EN && (tmo_cnt_q != TMO_LIM)) begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end else begin
                tmo_cnt_d = tmo_cnt_q;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:  if (iniciar) estado_d = PREPARA;
            PREPARA:  estado_d = ESPERA;
            ESPERA: begin
                // A move that lands on the timeout cycle still counts.
                if (jogada_p) begin
                    estado_d = REGISTRA;
                end else if (tmo_hit) begin
                    estado_d = FIM_TIMEOUT;
                end
            end
            REGISTRA: estado_d = COMPARA;
            COMPARA: begin
                if (!chavesIgualMemoria) begin
                    estado_d = FIM_ERRO;
                end else if (fimC) begin
                    estado_d = FIM_ACERTO;
                end else begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO:  estado_d = ESPERA;
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (iniciar) estado_d = PREPARA;
            end
            default:  estado_d = INICIAL;
        endcase
    end

    // Outputs are registered from the next state, so they always equal decode(estado_q).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
            saidas_q <= '0;
        end else begin
            estado_q <= estado_d;
            saidas_q <= decode_saidas(estado_d);
        end
    end

    assign zeraC     = saidas_q.zera_c;
    assign contaC    = saidas_q.conta_c;
    assign zeraR     = saidas_q.zera_r;
    assign registraR = saidas_q.registra_r;
    assign pronto    = saidas_q.pronto;
    assign acertou   = saidas_q.acertou;
    assign errou     = saidas_q.errou;
    assign timeout   = saidas_q.timeout;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Bench for the memory-game control unit, wrapped in a small behavioural datapath
// (counter, switch register, synchronous ROM, comparator).
module tb_exp4_unidade_controle;
    import exp4_unidade_controle_pkg::*;

    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] chaves = 4'h0;
    logic       igual;
    logic       fim_c;
    logic       zeraC, contaC, zeraR, registraR;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;
    logic [7:0] all_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_registra = 0;
    int n_compara  = 0;

    logic [3:0] rom [16];
    logic [3:0] pv  [16];
    logic [3:0] dp_cnt = 4'h0;
    logic [3:0] dp_reg = 4'h0;
    logic [3:0] dp_rom_q = 4'h0;

    exp4_unidade_controle #(.TIMEOUT_CYCLES(TMO), .TW(13)) dut (
        .clock              (clk),
        .reset              (rst_n),
        .iniciar            (iniciar),
        .chaves             (chaves),
        .chavesIgualMemoria (igual),
        .fimC               (fim_c),
        .zeraC              (zeraC),
        .contaC             (contaC),
        .zeraR              (zeraR),
        .registraR          (registraR),
        .pronto             (pronto),
        .acertou            (acertou),
        .errou              (errou),
        .timeout            (timeout),
        .db_estado          (db_estado)
    );

    always #5 clk = ~clk;

    // Datapath around the controller.
    always @(posedge clk) begin
        if (zeraC) dp_cnt <= 4'h0;
        else if (contaC) dp_cnt <= dp_cnt + 4'd1;
        dp_rom_q <= rom[dp_cnt];
        if (zeraR) dp_reg <= 4'h0;
        else if (registraR) dp_reg <= chaves;
    end
    assign igual   = (dp_reg == dp_rom_q);
    assign fim_c   = (dp_cnt == 4'd15);
    assign all_out = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};

    always @(negedge clk) begin
        if (db_estado == EST_REGISTRA) n_registra++;
        if (db_estado == EST_COMPARA)  n_compara++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0; chaves = 4'h0; iniciar = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic start_round();
        iniciar = 1'b1;
        @(posedge clk); #1;
        iniciar = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_state(input logic [3:0] code, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (db_estado == code) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (db_estado == code) ok = 1'b1;
    endtask

    task automatic play_move(input logic [3:0] val, input int hold, output bit ok);
        wait_state(EST_ESPERA, 60, ok);
        if (ok) begin
            chaves = val;
            repeat (hold) @(posedge clk);
            #1 chaves = 4'h0;
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    // Reference: the round ends at the first move that differs from ROM, or after 16 matches.
    task automatic model_round(input int n, output logic [3:0] st, output int moves, output int addr);
        st = EST_ESPERA; moves = 0; addr = 0;
        for (int i = 0; i < n; i++) begin
            moves = i + 1;
            addr  = i;
            if (pv[i] != rom[i]) begin
                st = EST_FIM_ERRO;
                break;
            end
            if (i == 15) begin
                st = EST_FIM_ACERTO;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit ok;
        do_reset();
        n_checks++;
        if (db_estado !== EST_INICIAL) $display("FAIL reset_state: got %0h expected %0h", db_estado, EST_INICIAL);
        else n_pass++;
        n_checks++;
        if (all_out !== 8'h00) $display("FAIL reset_outputs: got %b expected 00000000", all_out);
        else n_pass++;
        iniciar = 1'b1;
        @(posedge clk); #1;
        iniciar = 1'b0;
        n_checks++;
        if (db_estado !== EST_PREPARA) $display("FAIL start_prepara: got %0h expected %0h", db_estado, EST_PREPARA);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (db_estado !== EST_ESPERA) $display("FAIL start_espera: got %0h expected %0h", db_estado, EST_ESPERA);
        else n_pass++;
        chaves = rom[0];
        wait_state(EST_REGISTRA, 10, ok);
        n_checks++;
        if (!ok || registraR !== 1'b1) $display("FAIL reach_registra: got state %0h registraR %b expected 4 and 1", db_estado, registraR);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (db_estado !== EST_INICIAL || all_out !== 8'h00)
            $display("FAIL async_reset: got state %0h outputs %b expected 0 and 00000000", db_estado, all_out);
        else n_pass++;
        chaves = 4'h0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        iniciar = 1'b1;
        @(posedge clk); #1;
        iniciar = 1'b0;
        n_checks++;
        if (db_estado !== EST_PREPARA) $display("FAIL restart_prepara: got %0h expected %0h", db_estado, EST_PREPARA);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (db_estado !== EST_ESPERA) $display("FAIL restart_espera: got %0h expected %0h", db_estado, EST_ESPERA);
        else n_pass++;
    endtask

    task automatic test_acerto();
        bit ok;
        logic [3:0] exp_st;
        int moves, addr, r0;
        do_reset();
        start_round();
        for (int i = 0; i < 16; i++) pv[i] = rom[i];
        model_round(16, exp_st, moves, addr);
        r0 = n_registra;
        for (int i = 0; i < 16; i++) play_move(pv[i], $urandom_range(4, 8), ok);
        wait_state(exp_st, 20, ok);
        n_checks++;
        if (db_estado !== exp_st) $display("FAIL acerto_state: got %0h expected %0h", db_estado, exp_st);
        else n_pass++;
        n_checks++;
        if ({pronto, acertou, errou, timeout} !== 4'b1100)
            $display("FAIL acerto_flags: got %b expected 1100", {pronto, acertou, errou, timeout});
        else n_pass++;
        n_checks++;
        if (n_registra - r0 !== moves) $display("FAIL acerto_moves: got %0d expected %0d", n_registra - r0, moves);
        else n_pass++;
        n_checks++;
        if (dp_cnt !== 4'(addr)) $display("FAIL acerto_addr: got %0d expected %0d", dp_cnt, addr);
        else n_pass++;
    endtask

    task automatic test_erro(input int k);
        bit ok;
        logic [3:0] exp_st, w;
        int moves, addr, r0;
        do_reset();
        start_round();
        for (int i = 0; i < 16; i++) pv[i] = rom[i];
        do w = 4'($urandom_range(1, 15)); while (w == rom[k]);
        pv[k] = w;
        model_round(k + 1, exp_st, moves, addr);
        r0 = n_registra;
        for (int i = 0; i <= k; i++) play_move(pv[i], $urandom_range(4, 8), ok);
        wait_state(exp_st, 20, ok);
        n_checks++;
        if (db_estado !== exp_st) $display("FAIL erro_state k=%0d: got %0h expected %0h", k, db_estado, exp_st);
        else n_pass++;
        n_checks++;
        if ({pronto, acertou, errou, timeout} !== 4'b1010)
            $display("FAIL erro_flags k=%0d: got %b expected 1010", k, {pronto, acertou, errou, timeout});
        else n_pass++;
        n_checks++;
        if (dp_cnt !== 4'(addr)) $display("FAIL erro_contagem k=%0d: got %0d expected %0d", k, dp_cnt, addr);
        else n_pass++;
        n_checks++;
        if (n_registra - r0 !== moves) $display("FAIL erro_moves k=%0d: got %0d expected %0d", k, n_registra - r0, moves);
        else n_pass++;
    endtask

    // Entered from FIM_ERRO, left by test_erro.
    task automatic test_restart();
        bit ok;
        int r0;
        iniciar = 1'b1;
        @(posedge clk); #1;
        iniciar = 1'b0;
        n_checks++;
        if (db_estado !== EST_PREPARA || zeraC !== 1'b1 || zeraR !== 1'b1 || pronto !== 1'b0 || errou !== 1'b0)
            $display("FAIL restart_prep: got state %0h zeraC %b zeraR %b pronto %b errou %b expected 1 1 1 0 0",
                     db_estado, zeraC, zeraR, pronto, errou);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (db_estado !== EST_ESPERA || zeraC !== 1'b0 || dp_cnt !== 4'h0 || dp_reg !== 4'h0)
            $display("FAIL restart_clear: got state %0h zeraC %b addr %0d reg %0h expected 2 0 0 0",
                     db_estado, zeraC, dp_cnt, dp_reg);
        else n_pass++;
        r0 = n_registra;
        play_move(rom[0], 4, ok);
        n_checks++;
        if (db_estado !== EST_ESPERA || dp_cnt !== 4'h1 || n_registra - r0 !== 1)
            $display("FAIL restart_move: got state %0h addr %0d moves %0d expected 2 1 1", db_estado, dp_cnt, n_registra - r0);
        else n_pass++;
    endtask

    // p < 0: no press. Otherwise switches go high on ESPERA cycle p. The pulse reaches the FSM two cycles later.
    task automatic test_timeout(input int p);
        int c;
        int exp_len;
        logic [3:0] exp_st;
        do_reset();
        start_round();
        if (p >= 0 && p + 3 <= TMO) begin
            exp_len = p + 3;
            exp_st  = EST_REGISTRA;
        end else begin
            exp_len = TMO;
            exp_st  = EST_FIM_TIMEOUT;
        end
        c = 0;
        while (db_estado == EST_ESPERA && c < 100) begin
            if (c == p) chaves = rom[0];
            @(posedge clk); #1;
            c++;
        end
        n_checks++;
        if (c !== exp_len) $display("FAIL tmo_len p=%0d: got %0d expected %0d", p, c, exp_len);
        else n_pass++;
        n_checks++;
        if (db_estado !== exp_st) $display("FAIL tmo_state p=%0d: got %0h expected %0h", p, db_estado, exp_st);
        else n_pass++;
        if (exp_st == EST_FIM_TIMEOUT) begin
            n_checks++;
            if ({pronto, acertou, errou, timeout} !== 4'b1011)
                $display("FAIL tmo_flags p=%0d: got %b expected 1011", p, {pronto, acertou, errou, timeout});
            else n_pass++;
            repeat (5) @(posedge clk);
            #1;
            n_checks++;
            if (db_estado !== EST_FIM_TIMEOUT) $display("FAIL tmo_hold p=%0d: got %0h expected %0h", p, db_estado, EST_FIM_TIMEOUT);
            else n_pass++;
        end
        chaves = 4'h0;
    endtask

    task automatic test_hold();
        int r0, c0;
        do_reset();
        start_round();
        r0 = n_registra;
        c0 = n_compara;
        chaves = rom[0];
        repeat (10) @(posedge clk);
        #1 chaves = 4'h0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (n_registra - r0 !== 1 || n_compara - c0 !== 1)
            $display("FAIL hold_single: got registra %0d compara %0d expected 1 1", n_registra - r0, n_compara - c0);
        else n_pass++;
        n_checks++;
        if (db_estado !== EST_ESPERA || dp_cnt !== 4'h1)
            $display("FAIL hold_state: got state %0h addr %0d expected 2 1", db_estado, dp_cnt);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(1, 15));
        test_reset();
        test_acerto();
        test_erro(3);
        test_restart();
        test_erro($urandom_range(0, 15));
        test_erro(15);
        test_timeout(-1);
        test_timeout(17);
        test_timeout(18);
        test_timeout($urandom_range(0, 16));
        test_hold();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
